// File: rtl/ccff_loader_if.sv
// rtl/ccff_loader_if.sv - bus bundle between a host/chain and the ccff_loader
`timescale 1ns/1ps
interface ccff_loader_if #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              ccff_head;
  logic              chain_en;
  logic              ccff_tail;
  logic [WORD_W-1:0] rb_word;
  logic              rb_valid;
  logic              busy;
  logic              done;

  // Host side: issues loads, supplies words, and presents the chain tail.
  modport master (
    output start, cfg_len, word_in, word_valid, ccff_tail,
    input  word_ready, ccff_head, chain_en, rb_word, rb_valid, busy, done
  );

  // Loader side.
  modport slave (
    input  start, cfg_len, word_in, word_valid, ccff_tail,
    output word_ready, ccff_head, chain_en, rb_word, rb_valid, busy, done
  );
endinterface

// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - serial config-chain loader with tail readback packer
`timescale 1ns/1ps
module ccff_loader #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic         i_prog_clk,
  input  logic         i_prog_reset,
  ccff_loader_if.slave bus
);
  localparam int IDX_W = $clog2(WORD_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SHIFT, ST_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LEN_W-1:0]  r_remaining;
  logic [WORD_W-1:0] r_buf;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              r_head;
  logic [WORD_W-1:0] r_rb_buf;
  logic [IDX_W-1:0]  r_rb_cnt;
  logic [WORD_W-1:0] r_rb_word;
  logic              r_rb_valid;

  logic              w_start_load;
  logic              w_accept;
  logic              w_shift;
  logic              w_last_bit;
  logic              w_rb_flush;
  logic [WORD_W-1:0] w_buf_nxt;
  logic [WORD_W-1:0] w_rb_packed;

  assign w_start_load = (r_state == ST_IDLE) && bus.start && (bus.cfg_len != '0);
  assign w_accept     = (r_state == ST_FETCH) && bus.word_valid;
  assign w_shift      = (r_state == ST_SHIFT);
  assign w_last_bit   = (r_remaining == LEN_W'(1));
  assign w_rb_flush   = (r_rb_cnt == LAST_IDX) || w_last_bit;
  assign w_rb_packed  = r_rb_buf | (WORD_W'(bus.ccff_tail) << r_rb_cnt);

  // Shift buffer for the next cycle: fresh word on accept, right shift while shifting.
  always_comb begin
    w_buf_nxt = r_buf;
    if (w_accept) begin
      w_buf_nxt = bus.word_in;
    end else if (w_shift) begin
      w_buf_nxt = r_buf >> 1;
    end
  end

  // Next-state decode; start only matters in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.cfg_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.word_valid) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_bit) begin
          w_state_nxt = ST_DONE;
        end else if (r_bit_idx == LAST_IDX) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any load and drops chain_en at once.
  always_ff @(posedge i_prog_clk or posedge i_prog_reset) begin
    if (i_prog_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bit counters, shift buffer, and the registered head bit that holds across stalls.
  always_ff @(posedge i_prog_clk or posedge i_prog_reset) begin
    if (i_prog_reset) begin
      r_remaining <= '0;
      r_buf       <= '0;
      r_bit_idx   <= '0;
      r_head      <= 1'b0;
    end else begin
      if (w_start_load) begin
        r_remaining <= bus.cfg_len;
      end else if (w_shift) begin
        r_remaining <= r_remaining - LEN_W'(1);
      end
      r_buf <= w_buf_nxt;
      if (w_accept) begin
        r_bit_idx <= '0;
      end else if (w_shift) begin
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end
      if (w_state_nxt == ST_SHIFT) begin
        r_head <= w_buf_nxt[0];
      end
    end
  end

  // Readback packer: collects the bit leaving the tail on every shift edge,
  // and emits a word when full or when the load ends on a partial word.
  always_ff @(posedge i_prog_clk or posedge i_prog_reset) begin
    if (i_prog_reset) begin
      r_rb_buf   <= '0;
      r_rb_cnt   <= '0;
      r_rb_word  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (w_shift) begin
        if (w_rb_flush) begin
          r_rb_word  <= w_rb_packed;
          r_rb_valid <= 1'b1;
          r_rb_buf   <= '0;
          r_rb_cnt   <= '0;
        end else begin
          r_rb_buf <= w_rb_packed;
          r_rb_cnt <= r_rb_cnt + IDX_W'(1);
        end
      end
    end
  end

  assign bus.word_ready = (r_state == ST_FETCH);
  assign bus.chain_en   = (r_state == ST_SHIFT);
  assign bus.busy       = (r_state == ST_FETCH) || (r_state == ST_SHIFT);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.ccff_head  = r_head;
  assign bus.rb_word    = r_rb_word;
  assign bus.rb_valid   = r_rb_valid;
endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - directed self-checking bench for ccff_loader
`timescale 1ns/1ps
module tb_ccff_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_failed = 0;

  always #5 clk = ~clk;

  ccff_loader_if #(.WORD_W(32), .LEN_W(16)) if32 ();
  ccff_loader_if #(.WORD_W(8),  .LEN_W(16)) if8 ();

  ccff_loader #(.WORD_W(32), .LEN_W(16)) u_dut32 (
    .i_prog_clk  (clk),
    .i_prog_reset(rst),
    .bus         (if32)
  );

  ccff_loader #(.WORD_W(8), .LEN_W(16)) u_dut8 (
    .i_prog_clk  (clk),
    .i_prog_reset(rst),
    .bus         (if8)
  );

  // Chain models: head enters at the top, tail leaves from bit 0; not reset.
  logic [11:0] chain32 = '0;
  logic [7:0]  chain8  = '0;
  always @(posedge clk) begin
    if (if32.chain_en) chain32 <= {if32.ccff_head, chain32[11:1]};
    if (if8.chain_en)  chain8  <= {if8.ccff_head, chain8[7:1]};
  end
  assign if32.ccff_tail = chain32[0];
  assign if8.ccff_tail  = chain8[0];

  // Observation of the 8-bit instance, sampled on the falling edge.
  int          en8 = 0;
  int          tog8 = 0;
  int          rbv8 = 0;
  logic [19:0] head8 = '0;
  logic [7:0]  rbw8 [0:2];
  logic        prev_head8 = 1'b0;
  always @(negedge clk) begin
    if (if8.chain_en) begin
      if (en8 < 20) head8[en8] = if8.ccff_head;
      en8++;
    end
    if (if8.word_ready && (if8.ccff_head !== prev_head8)) tog8++;
    if (if8.rb_valid) begin
      if (rbv8 < 3) rbw8[rbv8] = if8.rb_word;
      rbv8++;
    end
    prev_head8 = if8.ccff_head;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 12-bit load of 0xABC on the 32-bit instance, checked cycle by cycle.
  task automatic load32(input string tag, input bit stray_start, input logic [31:0] exp_rb);
    logic [11:0] pat;
    pat = 12'hABC;
    if32.start      = 1'b1;
    if32.cfg_len    = 16'd12;
    if32.word_in    = 32'h0000_0ABC;
    if32.word_valid = 1'b1;
    tick();
    if32.start = 1'b0;
    check({tag, "_fetch"}, 64'({if32.busy, if32.word_ready, if32.chain_en, if32.done}), 64'b1100);
    tick();
    if32.word_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("%s_shift%0d", tag, i),
            64'({if32.chain_en, if32.busy, if32.done, if32.word_ready, if32.ccff_head}),
            64'({4'b1100, pat[i]}));
      if (stray_start && i == 3) begin
        if32.start   = 1'b1;
        if32.cfg_len = 16'd5;
      end else begin
        if32.start = 1'b0;
      end
      tick();
    end
    check({tag, "_done"}, 64'({if32.done, if32.busy, if32.chain_en, if32.rb_valid}), 64'b1001);
    check({tag, "_rb"}, 64'(if32.rb_word), 64'(exp_rb));
    tick();
    check({tag, "_idle"}, 64'({if32.done, if32.rb_valid, if32.busy}), 64'b000);
  endtask

  initial begin
    bit seen;
    if32.start = 1'b0; if32.cfg_len = '0; if32.word_in = '0; if32.word_valid = 1'b0;
    if8.start  = 1'b0; if8.cfg_len  = '0; if8.word_in  = '0; if8.word_valid  = 1'b0;

    // Reset values
    tick();
    check("reset_outs", 64'({if32.word_ready, if32.ccff_head, if32.chain_en, if32.rb_valid,
                             if32.busy, if32.done, if32.rb_word}), 64'd0);
    check("reset_outs8", 64'({if8.word_ready, if8.ccff_head, if8.chain_en, if8.rb_valid,
                              if8.busy, if8.done, if8.rb_word}), 64'd0);
    rst = 1'b0;
    tick();

    // First load reads back the zeroed chain; second reads back the first.
    load32("load1", 1'b0, 32'h0000_0000);
    tick();
    load32("load2", 1'b1, 32'h0000_0ABC);
    tick();

    // Zero-length start
    if32.start   = 1'b1;
    if32.cfg_len = 16'd0;
    tick();
    if32.start = 1'b0;
    check("len0_done", 64'({if32.done, if32.busy, if32.word_ready, if32.chain_en, if32.rb_valid}), 64'b10000);
    tick();
    check("len0_after", 64'({if32.done, if32.busy, if32.word_ready, if32.chain_en, if32.rb_valid}), 64'b00000);

    // Reset during the 5th SHIFT cycle: four bits have entered the chain.
    if32.start = 1'b1; if32.cfg_len = 16'd12; if32.word_in = 32'h0000_0ABC; if32.word_valid = 1'b1;
    tick();
    if32.start = 1'b0;
    tick();
    if32.word_valid = 1'b0;
    repeat (4) tick();
    check("abort_pre", 64'({if32.chain_en, if32.busy}), 64'b11);
    #2;
    rst = 1'b1;
    #1;
    check("abort_async", 64'({if32.chain_en, if32.busy, if32.done, if32.word_ready, if32.rb_valid}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("abort_stays", 64'({if32.chain_en, if32.busy, if32.done, if32.rb_valid}), 64'd0);
    load32("fresh", 1'b0, 32'h0000_0CAB);
    tick();

    // 8-bit words, 20-bit load with a 5-cycle stall before the second word.
    if8.start = 1'b1; if8.cfg_len = 16'd20; if8.word_in = 8'hA5; if8.word_valid = 1'b1;
    tick();
    if8.start = 1'b0;
    tick();
    if8.word_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      seen = if8.word_ready;
    end
    check("w8_fetch2", 64'(seen), 64'd1);
    repeat (4) tick();
    check("w8_stalled", 64'({if8.word_ready, if8.chain_en, if8.busy}), 64'b101);
    if8.word_in = 8'h3C; if8.word_valid = 1'b1;
    tick();
    if8.word_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      seen = if8.word_ready;
    end
    check("w8_fetch3", 64'(seen), 64'd1);
    if8.word_in = 8'h0F; if8.word_valid = 1'b1;
    tick();
    if8.word_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      seen = if8.done;
    end
    check("w8_done", 64'(seen), 64'd1);
    tick();
    tick();
    check("w8_en_cycles", 64'(en8), 64'd20);
    check("w8_head_bits", 64'(head8), 64'h0F3CA5);
    check("w8_stall_toggle", 64'(tog8), 64'd0);
    check("w8_rb_count", 64'(rbv8), 64'd3);
    check("w8_rb0", 64'(rbw8[0]), 64'h00);
    check("w8_rb1", 64'(rbw8[1]), 64'hA5);
    check("w8_rb2", 64'(rbw8[2]), 64'h0C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end
endmodule
